// File: rtl/bus_ram.sv
// bus_ram: read/write RAM responder for the nqcpu memory bus with a decoded
// address window and a fixed number of wait states per access.
module bus_ram #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addr_i,
  input  logic        re_i,
  input  logic        we_i,
  inout  wire  [15:0] data_io,
  output logic        needWait_o
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES);
  // With a single wait cycle the stall is the request cycle itself, so the
  // access goes straight to ACK and WAIT is never visited.
  localparam bit SINGLE_WAIT = (WAIT_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    kind_q, kind_d;
  logic [DW-1:0]           data_q, data_d;

  logic [DW-1:0]           mem [DEPTH];

  logic                    sel_c;
  logic                    req_c;
  logic                    same_c;
  logic                    wr_en_c;
  logic                    drive_c;
  logic                    need_wait_c;
  logic                    start_c;
  logic                    load_c;
  logic [ADDR_WIDTH-1:0]   rd_addr_c;
  logic [CW-1:0]           cnt_inc_c;

  // Request decode against the address window and the latched access.
  always_comb begin
    sel_c     = (addr_i[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH]);
    req_c     = sel_c & (re_i | we_i);
    same_c    = (addr_i[ADDR_WIDTH-1:0] == addr_q) && (we_i == kind_q);
    cnt_inc_c = CW'(cnt_q + CW'(1));
    wr_en_c   = (state_q == ST_ACK) && kind_q;
    drive_c   = ((state_q == ST_ACK) || (state_q == ST_HOLD)) &&
                !kind_q && re_i && !we_i && sel_c;
  end

  // Next-state, stall and read-data capture logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    kind_d      = kind_q;
    data_d      = data_q;
    need_wait_c = 1'b0;
    start_c     = 1'b0;
    load_c      = 1'b0;
    rd_addr_c   = addr_q;

    case (state_q)
      ST_IDLE: begin
        need_wait_c = req_c;
        start_c     = req_c;
      end
      ST_WAIT: begin
        need_wait_c = req_c;
        if (!req_c || !same_c) begin
          state_d = ST_IDLE;
        end else if (cnt_inc_c >= WAIT_LAST) begin
          state_d = ST_ACK;
          cnt_d   = WAIT_LAST;
          load_c  = 1'b1;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      ST_ACK, ST_HOLD: begin
        need_wait_c = req_c & ~same_c;
        if (req_c && same_c) begin
          state_d = ST_HOLD;
        end else if (req_c) begin
          start_c = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_c) begin
      addr_d = addr_i[ADDR_WIDTH-1:0];
      kind_d = we_i;
      cnt_d  = CW'(1);
      if (SINGLE_WAIT) begin
        state_d   = ST_ACK;
        rd_addr_c = addr_i[ADDR_WIDTH-1:0];
        load_c    = 1'b1;
      end else begin
        state_d = ST_WAIT;
      end
    end

    // A read starting on the edge that commits a write to the same word
    // must see the committed value.
    if (load_c) begin
      if (wr_en_c && (rd_addr_c == addr_q)) begin
        data_d = data_io;
      end else begin
        data_d = mem[rd_addr_c];
      end
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      kind_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      kind_q  <= kind_d;
      data_q  <= data_d;
    end
  end

  // Storage array, committed once at the edge ending ACK; never reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[addr_q] <= data_io;
    end
  end

  assign needWait_o = need_wait_c & reset_n;
  assign data_io    = drive_c ? data_q : {DW{1'bz}};

endmodule

// File: doc/bus_ram.md
# bus_ram

Read/write RAM responder for the nqcpu memory bus. It is the write-capable counterpart of testROM and sits on the same `addr_o` / `re_o` / `we_o` / `data_io` / `needWait_i` interface driven by the CPU. It decodes a parameterised address window and inserts a programmable number of wait states per access. Reads are served from a registered output; each write is committed exactly once per access.

## Interface
- ADDR_WIDTH, 12: word-address bits of internal storage; depth = 2^ADDR_WIDTH 16-bit words.
- BASE_ADDR, 16'h8000: window base; only bits [15:ADDR_WIDTH] are compared.
- WAIT_CYCLES, 2: cycles `needWait_o` is high per access; legal range 1..15.
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- addr_i  input  16  word address from the CPU.
- re_i  input  1  read request, level.
- we_i  input  1  write request, level.
- data_io  inout  16  shared data bus; driven by this block only during read completion, otherwise high-Z.
- needWait_o  output  1  stall request to the CPU; combinational from state and request.

## Operation
- sel = (addr_i[15:ADDR_WIDTH] == BASE_ADDR[15:ADDR_WIDTH]); req = sel & (re_i | we_i); kind = we_i (write has priority when both are high; block then never drives `data_io`).
- Latched on every accepted request: addr_q = addr_i[ADDR_WIDTH-1:0], kind_q; 4-bit counter cnt.
- States:
  - IDLE: needWait_o = req. If req: go to WAIT, cnt = 1, latch addr and kind.
  - WAIT: needWait_o = 1 while cnt < WAIT_CYCLES; cnt increments each cycle. Once cnt == WAIT_CYCLES at an edge: data_q <= mem[addr_q] and the next state is ACK. If req drops, or addr/kind differs from the latched values: abort to IDLE (a new request is taken up from IDLE), no write.
  - ACK: needWait_o = 0. Read: data_io = data_q. Write: mem[addr_q] <= data_io at the edge ending ACK. Next state is HOLD if the same request persists, WAIT with cnt = 1 if a different request is present (new addr or kind, latched), otherwise IDLE.
  - HOLD: needWait_o = 0. Read keeps driving data_q; write does nothing further. Same transitions as ACK.
- data_io is driven only when state ∈ {ACK, HOLD} & kind_q = read & re_i & ~we_i & sel. Otherwise 'z.
- A request outside the window is ignored: needWait_o = 0, no drive, no state change from IDLE.
- Memory contents are not reset and are uninitialised at power-up.

## Timing
- Reset values: state IDLE, cnt 0, needWait_o 0, data_io high-Z, data_q 0. Asynchronous assertion mid-access aborts it with no write; memory is preserved.
- Read latency: request visible in cycle T; needWait_o is high in cycles T..T+WAIT_CYCLES-1; data is valid and needWait_o is low at cycle T+WAIT_CYCLES.
- Write: needWait_o pattern is identical; memory updates at the edge ending cycle T+WAIT_CYCLES, using data_io sampled at that edge.
- Back-to-back accesses without deasserting re_i/we_i are detected by an address or kind change and restart the WAIT count, so each costs WAIT_CYCLES stall cycles.
- A request withdrawn during WAIT costs nothing further; needWait_o falls combinationally in the same cycle.
- cnt saturates at WAIT_CYCLES; no wrap.

## Test plan
- Reset with re_i high at 16'h8004 -> needWait_o 0, data_io Z; after release, needWait_o high 2 cycles, then still 0 data (memory uninitialised region excluded from check).
- Write 16'hBEEF to 16'h8010 (WAIT_CYCLES=2) -> needWait_o high exactly 2 cycles, low in cycle 3; read of 16'h8010 then returns 16'hBEEF on cycle 3 with needWait_o low.
- Write held asserted 5 cycles past ACK while the CPU changes data_io to 16'h1234 -> stored value remains the ACK-cycle value 16'hBEEF.
- Back-to-back reads 16'h8010 then 16'h8011 with re_i held -> second read stalls 2 more cycles, returns its own data; no bus contention.
- Read at 16'h4000 (outside window) -> needWait_o 0, data_io Z for all cycles.
- reset_n pulsed low during WAIT of a write of 16'h5555 to 16'h8020 -> state IDLE, and location 16'h8020 keeps its prior value 16'hAAAA.
